// File: rtl/aabb_overlap_seq_pkg.sv
// Shared types and constants for the sequential AABB overlap checker.
// Contents: FSM state enum, axis codes, the "no separating axis" code,
// the default coordinate width and the index of the last subtraction step.
package coll_det_pkg;

    localparam int unsigned W_DEFAULT = 16;
    localparam int unsigned NUM_AXES  = 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam logic [1:0] AX_X     = 2'd0;
    localparam logic [1:0] AX_Y     = 2'd1;
    localparam logic [1:0] AX_Z     = 2'd2;
    localparam logic [1:0] SEP_NONE = 2'b11;

    // Two subtractions per axis, steps 0..5.
    localparam logic [2:0] LAST_STEP = 3'd5;

endpackage

// File: rtl/aabb_overlap_seq_if.sv
// Handshake and data bundle for aabb_overlap_seq.
// master: upstream/downstream side (drives boxes and out_ready).
// slave : the checker (drives in_ready and the result fields).
// Boxes are packed x=[W-1:0], y=[2W-1:W], z=[3W-1:2W].
interface aabb_overlap_seq_if
    import coll_det_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);
    logic           in_valid;
    logic           in_ready;
    logic [3*W-1:0] a_min;
    logic [3*W-1:0] a_max;
    logic [3*W-1:0] b_min;
    logic [3*W-1:0] b_max;
    logic           out_valid;
    logic           out_ready;
    logic           collide;
    logic [1:0]     sep_axis;
    logic [W-1:0]   min_overlap;

    modport master (
        output in_valid, a_min, a_max, b_min, b_max, out_ready,
        input  in_ready, out_valid, collide, sep_axis, min_overlap
    );

    modport slave (
        input  in_valid, a_min, a_max, b_min, b_max, out_ready,
        output in_ready, out_valid, collide, sep_axis, min_overlap
    );
endinterface

// File: rtl/aabb_overlap_seq_sub_borrow_w.sv
// Combinational W-bit subtractor: d = x - y (mod 2^W), borrow = (x < y).
// Ports: x, y (operands); d (difference); borrow (1 when x < y unsigned).
module sub_borrow_w #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] d,
    output logic         borrow
);
    logic [W:0] sum;

    // x + ~y + 1 in W+1 bits; the carry-out is the inverted borrow.
    assign sum    = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    assign d      = sum[W-1:0];
    assign borrow = ~sum[W];
endmodule

// File: rtl/aabb_overlap_seq.sv
// Sequential 3-axis AABB overlap checker. One shared subtractor evaluates
// six differences (two per axis), one per cycle, exiting on the first borrow.
// Ports: clk, rst (sync, active-high); bus (slave modport): in_valid/in_ready,
// a_min/a_max/b_min/b_max boxes, out_valid/out_ready, collide, sep_axis,
// min_overlap.
module aabb_overlap_seq
    import coll_det_pkg::*;
#(
    parameter int unsigned W    = W_DEFAULT,
    parameter int unsigned AXES = NUM_AXES
) (
    input logic               clk,
    input logic               rst,
    aabb_overlap_seq_if.slave bus
);
    state_e         state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [3*W-1:0] a_min_q, a_min_d, a_max_q, a_max_d;
    logic [3*W-1:0] b_min_q, b_min_d, b_max_q, b_max_d;
    logic [W-1:0]   run_min_q, run_min_d;
    logic           collide_q, collide_d;
    logic [1:0]     sep_q, sep_d;
    logic [W-1:0]   min_ov_q, min_ov_d;

    logic [W-1:0]   a_min_ax [AXES];
    logic [W-1:0]   a_max_ax [AXES];
    logic [W-1:0]   b_min_ax [AXES];
    logic [W-1:0]   b_max_ax [AXES];
    logic [1:0]     axis;
    logic [W-1:0]   op_x, op_y, diff, new_min;
    logic           borrow;

    always_comb begin
        for (int unsigned i = 0; i < AXES; i++) begin
            a_min_ax[i] = a_min_q[i*W +: W];
            a_max_ax[i] = a_max_q[i*W +: W];
            b_min_ax[i] = b_min_q[i*W +: W];
            b_max_ax[i] = b_max_q[i*W +: W];
        end
    end

    assign axis = step_q[2:1];

    // Even step: a_max - b_min; odd step: b_max - a_min.
    always_comb begin
        op_x = '0;
        op_y = '0;
        case (axis)
            AX_X: begin
                op_x = step_q[0] ? b_max_ax[0] : a_max_ax[0];
                op_y = step_q[0] ? a_min_ax[0] : b_min_ax[0];
            end
            AX_Y: begin
                op_x = step_q[0] ? b_max_ax[1] : a_max_ax[1];
                op_y = step_q[0] ? a_min_ax[1] : b_min_ax[1];
            end
            AX_Z: begin
                op_x = step_q[0] ? b_max_ax[2] : a_max_ax[2];
                op_y = step_q[0] ? a_min_ax[2] : b_min_ax[2];
            end
            default: ;
        endcase
    end

    sub_borrow_w #(
        .W (W)
    ) u_sub (
        .x      (op_x),
        .y      (op_y),
        .d      (diff),
        .borrow (borrow)
    );

    assign new_min = (diff < run_min_q) ? diff : run_min_q;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_min_d   = a_min_q;
        a_max_d   = a_max_q;
        b_min_d   = b_min_q;
        b_max_d   = b_max_q;
        run_min_d = run_min_q;
        collide_d = collide_q;
        sep_d     = sep_q;
        min_ov_d  = min_ov_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_min_d   = bus.a_min;
                    a_max_d   = bus.a_max;
                    b_min_d   = bus.b_min;
                    b_max_d   = bus.b_max;
                    step_d    = '0;
                    run_min_d = '1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (borrow) begin
                    collide_d = 1'b0;
                    sep_d     = axis;
                    min_ov_d  = '0;
                    state_d   = DONE;
                end else begin
                    run_min_d = new_min;
                    if (step_q == LAST_STEP) begin
                        collide_d = 1'b1;
                        sep_d     = SEP_NONE;
                        min_ov_d  = new_min;
                        state_d   = DONE;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            a_min_q   <= '0;
            a_max_q   <= '0;
            b_min_q   <= '0;
            b_max_q   <= '0;
            run_min_q <= '1;
            collide_q <= 1'b0;
            sep_q     <= SEP_NONE;
            min_ov_q  <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_min_q   <= a_min_d;
            a_max_q   <= a_max_d;
            b_min_q   <= b_min_d;
            b_max_q   <= b_max_d;
            run_min_q <= run_min_d;
            collide_q <= collide_d;
            sep_q     <= sep_d;
            min_ov_q  <= min_ov_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.collide     = collide_q;
    assign bus.sep_axis    = sep_q;
    assign bus.min_overlap = min_ov_q;
endmodule

// File: tb/tb_aabb_overlap_seq.sv
// Self-checking bench for aabb_overlap_seq: directed cases, backpressure,
// mid-calculation reset and randomized pairs against a behavioural model.
module tb_aabb_overlap_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    aabb_overlap_seq_if #(.W(16)) bus ();

    aabb_overlap_seq #(
        .W    (16),
        .AXES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pack3(input int unsigned x, input int unsigned y,
                                          input int unsigned z);
        logic [15:0] xs, ys, zs;
        xs = x[15:0];
        ys = y[15:0];
        zs = z[15:0];
        return {zs, ys, xs};
    endfunction

    // Reference: separation test per axis in step order, overlap depth as min of both spans.
    function automatic void ref_model(input logic [47:0] amin, input logic [47:0] amax,
                                      input logic [47:0] bmin, input logic [47:0] bmax,
                                      output logic col, output logic [1:0] sep,
                                      output logic [15:0] mo, output int lat);
        int unsigned best;
        int unsigned a_lo, a_hi, b_lo, b_hi, d1, d2;
        best = 32'hFFFF;
        col  = 1'b1;
        sep  = 2'b11;
        mo   = '0;
        lat  = 6;
        for (int ax = 0; ax < 3; ax++) begin
            a_lo = int'(amin[16*ax +: 16]);
            a_hi = int'(amax[16*ax +: 16]);
            b_lo = int'(bmin[16*ax +: 16]);
            b_hi = int'(bmax[16*ax +: 16]);
            if (a_hi < b_lo) begin
                col = 1'b0;
                sep = ax[1:0];
                lat = 2 * ax + 1;
                return;
            end
            if (b_hi < a_lo) begin
                col = 1'b0;
                sep = ax[1:0];
                lat = 2 * ax + 2;
                return;
            end
            d1 = a_hi - b_lo;
            d2 = b_hi - a_lo;
            if (d1 < best) best = d1;
            if (d2 < best) best = d2;
        end
        mo = best[15:0];
    endfunction

    // Present one pair, wait for the result, apply `hold` cycles of backpressure, retire it.
    task automatic run_pair(input string tag, input logic [47:0] amin, input logic [47:0] amax,
                            input logic [47:0] bmin, input logic [47:0] bmax,
                            input logic e_col, input logic [1:0] e_sep,
                            input logic [15:0] e_mo, input int e_lat, input int hold);
        int cyc;
        check_eq({tag, ":in_ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.a_min    = amin;
        bus.a_max    = amax;
        bus.b_min    = bmin;
        bus.b_max    = bmax;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a_min    = {$urandom, $urandom};
        bus.a_max    = {$urandom, $urandom};
        bus.b_min    = {$urandom, $urandom};
        bus.b_max    = {$urandom, $urandom};
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq({tag, ":latency"}, 32'(cyc), 32'(e_lat));
        check_eq({tag, ":collide"}, 32'(bus.collide), 32'(e_col));
        check_eq({tag, ":sep_axis"}, 32'(bus.sep_axis), 32'(e_sep));
        check_eq({tag, ":min_overlap"}, 32'(bus.min_overlap), 32'(e_mo));
        check_eq({tag, ":in_ready_done"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check_eq({tag, ":hold_fields"},
                     {13'd0, bus.collide, bus.sep_axis, bus.min_overlap},
                     {13'd0, e_col, e_sep, e_mo});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, ":retire_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, ":retire_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, ":retire_fields"},
                 {13'd0, bus.collide, bus.sep_axis, bus.min_overlap},
                 {13'd0, e_col, e_sep, e_mo});
    endtask

    logic [47:0] a0, a1, b0, b1;
    logic        m_col;
    logic [1:0]  m_sep;
    logic [15:0] m_mo;
    int          m_lat;
    int          seen_valid;

    function automatic int unsigned rnd_coord();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 65535);
        return $urandom_range(0, 40);
    endfunction

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_min     = '0;
        bus.a_max     = '0;
        bus.b_min     = '0;
        bus.b_max     = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("reset:in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset:out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset:collide", 32'(bus.collide), 32'd0);
        check_eq("reset:sep_axis", 32'(bus.sep_axis), 32'd3);
        check_eq("reset:min_overlap", 32'(bus.min_overlap), 32'd0);

        // Overlap, min depth 2 on y.
        run_pair("overlap", pack3(0, 0, 0), pack3(10, 10, 10), pack3(5, 8, 2),
                 pack3(20, 20, 20), 1'b1, 2'd3, 16'd2, 6, 0);
        // Separated on y, borrow at step 2.
        run_pair("sep_y", pack3(0, 0, 0), pack3(10, 10, 10), pack3(5, 11, 5),
                 pack3(8, 15, 8), 1'b0, 2'd1, 16'd0, 3, 0);
        // Touching faces count as collision with zero depth.
        run_pair("touch", pack3(0, 0, 0), pack3(10, 10, 10), pack3(10, 0, 0),
                 pack3(20, 10, 10), 1'b1, 2'd3, 16'd0, 6, 0);
        // Extreme coordinates, borrow at step 1.
        run_pair("extreme", pack3(16'hFFF0, 0, 0), pack3(16'hFFFF, 5, 5), pack3(0, 0, 0),
                 pack3(16'h000F, 5, 5), 1'b0, 2'd0, 16'd0, 2, 0);

        // Reset during step 3 of the overlap case drops the result.
        bus.a_min    = pack3(0, 0, 0);
        bus.a_max    = pack3(10, 10, 10);
        bus.b_min    = pack3(5, 8, 2);
        bus.b_max    = pack3(20, 20, 20);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst:out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst:in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst:sep_axis", 32'(bus.sep_axis), 32'd3);
        check_eq("midrst:collide", 32'(bus.collide), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen_valid++;
        end
        check_eq("midrst:no_result", 32'(seen_valid), 32'd0);
        run_pair("replay_sep_y", pack3(0, 0, 0), pack3(10, 10, 10), pack3(5, 11, 5),
                 pack3(8, 15, 8), 1'b0, 2'd1, 16'd0, 3, 0);

        // Backpressure then back-to-back second pair.
        run_pair("bp_overlap", pack3(0, 0, 0), pack3(10, 10, 10), pack3(5, 8, 2),
                 pack3(20, 20, 20), 1'b1, 2'd3, 16'd2, 6, 5);
        run_pair("bp_next", pack3(0, 0, 0), pack3(10, 10, 10), pack3(5, 11, 5),
                 pack3(8, 15, 8), 1'b0, 2'd1, 16'd0, 3, 0);

        for (int n = 0; n < 60; n++) begin
            a0 = pack3(rnd_coord(), rnd_coord(), rnd_coord());
            a1 = pack3(rnd_coord(), rnd_coord(), rnd_coord());
            b0 = pack3(rnd_coord(), rnd_coord(), rnd_coord());
            b1 = pack3(rnd_coord(), rnd_coord(), rnd_coord());
            ref_model(a0, a1, b0, b1, m_col, m_sep, m_mo, m_lat);
            run_pair("rand", a0, a1, b0, b1, m_col, m_sep, m_mo, m_lat,
                     int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
